ultrasonic_ranger: RTL and testbench
====================================

# ultrasonic_ranger

Self-timed ultrasonic range finder for HC-SR04-class sensors. It periodically fires a trigger pulse, measures the echo pulse width, and converts it to whole centimetres without a divider. It flags out-of-range or missing echoes, and drives a held in-window indicator against runtime-programmable limits. It replaces fixed-window LED control logic, feeding distance data to downstream display/game logic and the indicator straight to a LED.

## Interface
Parameters:
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 us at 50 MHz).
- CM_CYCLES, 2950: echo-high cycles per centimetre (59 us at 50 MHz).
- TIMEOUT_CYCLES, 1_200_000: max cycles waiting for echo rise, and max echo-high cycles.
- PERIOD_CYCLES, 3_000_000: trigger-to-trigger period; must be ≥ TRIG_CYCLES + 2·TIMEOUT_CYCLES + 4.
- MAX_CM, 400: distance saturation value.
- DIST_W, 9: distance width; 2^DIST_W > MAX_CM.
- HOLD_CYCLES, 1001: in_window hold time after the last in-window measurement.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allows new measurement cycles.
- echo  in  1  raw sensor echo, asynchronous.
- win_lo  in  DIST_W  window lower bound, exclusive, cm.
- win_hi  in  DIST_W  window upper bound, exclusive, cm.
- trig  out  1  sensor trigger.
- busy  out  1  high in any state except IDLE.
- dist_cm  out  DIST_W  last valid distance.
- dist_valid  out  1  one-cycle pulse when dist_cm updates.
- timeout  out  1  one-cycle pulse on missing or over-long echo.
- in_window  out  1  held window-hit indicator.

## Operation
- echo passes through a 2-FF synchroniser to give echo_s. Edges are detected on echo_s against its registered copy.
- The FSM has states IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
  - IDLE: when enable=1, go to TRIG and clear the period counter.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
  - WAIT_RISE: on an echo_s rising edge, go to MEASURE with the sub-counter and cm-counter cleared. If TIMEOUT_CYCLES cycles elapse without a rise, pulse timeout and go to GAP.
  - MEASURE: each cycle with echo_s=1, increment the sub-counter. When it reaches CM_CYCLES-1, wrap it to 0 and increment the cm-counter, saturating at MAX_CM. On an echo_s falling edge, load dist_cm from the cm-counter, pulse dist_valid, and go to GAP. If echo_s stays high TIMEOUT_CYCLES cycles, pulse timeout, keep dist_cm, and go to GAP.
  - GAP: wait until the period counter reaches PERIOD_CYCLES-1, then go to IDLE.
- The period counter runs from TRIG entry through GAP.
- Result: dist_cm = min(floor(N / CM_CYCLES), MAX_CM), where N is the number of echo_s-high cycles.
- enable=0 in any state forces IDLE on the next edge, drops trig, and discards any partial measurement. No dist_valid or timeout pulse is produced.
- Window check:
  - On a dist_valid cycle, if win_lo < dist_cm_new < win_hi, load the hold counter with HOLD_CYCLES and set in_window=1.
  - Otherwise the hold counter keeps counting down.
  - in_window clears on the cycle the counter reaches 0.
  - A new hit reloads the counter, so the hold is retriggerable.
  - timeout does not affect in_window.
- win_lo/win_hi are sampled only on the dist_valid cycle. If win_lo ≥ win_hi, no hit is possible.

## Timing
- Reset values: trig=0, busy=0, dist_cm=0, dist_valid=0, timeout=0, in_window=0. FSM is in IDLE; all counters and synchroniser flops are 0.
- Reset asserted mid-measurement aborts immediately; no pulses are emitted.
- First trig rises 1 cycle after enable is sampled high in IDLE.
- Echo latency: 2 sync cycles + 1 edge-detect cycle. dist_valid fires 3 cycles after the raw echo falls.
- dist_valid and timeout are mutually exclusive, and at most one fires per period.
- in_window rises in the same cycle as dist_valid, since both are registered together.
- An echo already high when WAIT_RISE is entered does not count as a rise; a clean 0→1 transition is required.

## Test plan
Use small parameters throughout: CM_CYCLES=10, TRIG_CYCLES=5, TIMEOUT_CYCLES=200, PERIOD_CYCLES=500, HOLD_CYCLES=50, win_lo=1, win_hi=5.
- **Reset/idle:** rst pulse, enable=0 for 100 cycles -> all outputs stay 0, trig never rises.
- **Nominal:** enable=1; echo high for 34 cycles, 20 cycles after the trig fall -> trig high exactly 5 cycles; dist_cm=3; one dist_valid pulse; in_window=1 for 50 cycles then 0; next trig 500 cycles after the previous one.
- **Window edges:** echo widths of 10, 50, and 49 cycles -> dist_cm 1, 5, 4 respectively; in_window is set only for 4, because bounds are exclusive.
- **Timeout:** no echo -> timeout pulse 200 cycles after WAIT_RISE entry, dist_cm unchanged. Echo held high for 300 cycles -> timeout pulse, no dist_valid.
- **Saturation:** with MAX_CM=15, TIMEOUT_CYCLES=400, PERIOD_CYCLES=900, echo high 180 cycles -> dist_cm=15.
- **Abort/retrigger:** enable drops mid-MEASURE -> IDLE next cycle, no pulses. Two in-window hits 30 cycles apart -> in_window stays high for 80 cycles total.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// Periodic HC-SR04 ranger: fires trig, times the echo into whole cm with a sub-counter, flags timeouts, holds a window-hit flag.
// Result lands 3 cycles after the raw echo falls; enable low drops to IDLE on the next edge with no pulses.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2950,
  parameter int TIMEOUT_CYCLES = 1_200_000,
  parameter int PERIOD_CYCLES  = 3_000_000,
  parameter int MAX_CM         = 400,
  parameter int DIST_W         = 9,
  parameter int HOLD_CYCLES    = 1001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo,
  input  logic [DIST_W-1:0] win_lo,
  input  logic [DIST_W-1:0] win_hi,
  output logic              trig,
  output logic              busy,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout,
  output logic              in_window
);

  localparam int TMAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
  localparam int PW   = $clog2(PERIOD_CYCLES);
  localparam int HW   = $clog2(HOLD_CYCLES + 1);

  localparam logic [TW-1:0]     TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]     SUB_LAST  = SW'(CM_CYCLES - 1);
  localparam logic [PW-1:0]     GAP_LAST  = PW'(PERIOD_CYCLES - 2);
  localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLD_CYCLES);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  state_t            state;
  logic              echo_m, echo_s, echo_d;
  logic [TW-1:0]     timer;
  logic [SW-1:0]     sub;
  logic [DIST_W-1:0] cm;
  logic [PW-1:0]     period;
  logic [HW-1:0]     hold;
  logic              rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      trig       <= 1'b0;
      busy       <= 1'b0;
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      in_window  <= 1'b0;
      timer      <= '0;
      sub        <= '0;
      cm         <= '0;
      period     <= '0;
      hold       <= '0;
    end else begin
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      timer      <= timer + TW'(1);
      if (state != IDLE) period <= period + PW'(1);
      // The hold timer runs independently of the FSM; a new hit below overrides it.
      if (hold != '0) begin
        hold <= hold - HW'(1);
        if (hold == HW'(1)) in_window <= 1'b0;
      end

      if (!enable) begin
        state <= IDLE;
        trig  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= TRIG;
            trig   <= 1'b1;
            busy   <= 1'b1;
            period <= '0;
            timer  <= '0;
          end
          TRIG: if (timer == TRIG_LAST) begin
            state <= WAIT_RISE;
            trig  <= 1'b0;
            timer <= '0;
          end
          WAIT_RISE: begin
            if (rise) begin
              // The rise cycle is itself the first echo-high cycle, so it is counted here.
              state <= MEASURE;
              timer <= TW'(1);
              sub   <= (CM_CYCLES == 1) ? '0 : SW'(1);
              cm    <= (CM_CYCLES == 1) ? DIST_W'(1) : '0;
            end else if (timer == TO_LAST) begin
              state   <= GAP;
              timeout <= 1'b1;
            end
          end
          MEASURE: begin
            if (fall) begin
              state      <= GAP;
              dist_cm    <= cm;
              dist_valid <= 1'b1;
              if (win_lo < cm && cm < win_hi) begin
                hold      <= HOLD_LOAD;
                in_window <= 1'b1;
              end
            end else if (timer == TO_LAST) begin
              state   <= GAP;
              timeout <= 1'b1;
            end else if (sub == SUB_LAST) begin
              sub <= '0;
              if (cm != CM_MAX) cm <= cm + DIST_W'(1);
            end else begin
              sub <= sub + SW'(1);
            end
          end
          GAP: if (period >= GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            trig  <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomized bench for ultrasonic_ranger: drives echo pulses against trig and checks every output each cycle against a timing model.
module tb_ultrasonic_ranger;

  logic       clk = 1'b0;
  logic       rst, enable, echo;
  logic [8:0] win_lo, win_hi;
  logic       trig, busy, dist_valid, timeout, in_window;
  logic [8:0] dist_cm;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .TRIG_CYCLES(5), .CM_CYCLES(10), .TIMEOUT_CYCLES(200), .PERIOD_CYCLES(500),
    .MAX_CM(15), .DIST_W(9), .HOLD_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo),
    .win_lo(win_lo), .win_hi(win_hi),
    .trig(trig), .busy(busy), .dist_cm(dist_cm),
    .dist_valid(dist_valid), .timeout(timeout), .in_window(in_window)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // Model state: raw echo schedule, expected pulse cycles, last distance, window hold end.
  int e_start = -1, e_end = -1;
  int exp_dv_cyc = -1, exp_to_cyc = -1;
  int hit_until = 0;
  int last_rise = -1;
  bit exp_hit = 1'b0;
  logic [8:0] exp_dist = '0, exp_dist_next = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, got, want);
    end
  endtask

  // One clock: drive echo just after the rising edge, check all pulses/state on the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1 echo = (cyc >= e_start && cyc < e_end);
    @(negedge clk);
    if (cyc == exp_dv_cyc) begin
      exp_dist = exp_dist_next;
      if (exp_hit) hit_until = cyc + 50;
    end
    chk("dist_valid", dist_valid, cyc == exp_dv_cyc);
    chk("timeout", timeout, cyc == exp_to_cyc);
    chk("dist_cm", dist_cm, exp_dist);
    chk("in_window", in_window, cyc < hit_until);
  endtask

  // mode 0: full period, 1: stop at dist_valid, 2: drop enable mid-echo, 3: reset mid-echo.
  task automatic measure(input int d, input int w, input int lo, input int hi, input bit cont, input int mode);
    int n, tr, tf, dn;
    win_lo = 9'(lo);
    win_hi = 9'(hi);
    n = 0;
    while (trig !== 1'b1 && n < 600) begin
      step();
      n++;
      if (cont && last_rise >= 0 && cyc == last_rise + 499) chk("busy_idle", busy, 0);
    end
    chk("trig_rise", trig, 1);
    chk("busy_run", busy, 1);
    tr = cyc;
    if (cont && last_rise >= 0) chk("period", tr - last_rise, 500);
    last_rise = tr;
    tf = tr + 5;
    exp_hit = 1'b0;
    if (w > 0) begin
      e_start = tf + d;
      e_end   = e_start + w;
    end
    if (w == 0 || d < -2) exp_to_cyc = tf + 200;
    else if (w >= 200) exp_to_cyc = e_start + 202;
    else begin
      dn = w / 10;
      if (dn > 15) dn = 15;
      exp_dist_next = 9'(dn);
      exp_hit = (lo < dn) && (dn < hi);
      exp_dv_cyc = e_end + 3;
    end
    n = 0;
    while (trig === 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("trig_width", n, 5);
    case (mode)
      1: while (cyc < exp_dv_cyc) step();
      2, 3: begin
        while (cyc < e_start + 30) step();
        exp_dv_cyc = -1;
        exp_to_cyc = -1;
        enable = 1'b0;
        if (mode == 3) begin
          rst = 1'b1;
          exp_dist = '0;
          hit_until = 0;
          last_rise = -1;
        end
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_trig", trig, 0);
        while (cyc < e_end + 250) step();
      end
      default: while (cyc < tr + 480) step();
    endcase
    e_start = -1;
    e_end = -1;
    exp_dv_cyc = -1;
    exp_to_cyc = -1;
  endtask

  task automatic restart();
    enable = 1'b1;
    step();
    chk("restart_trig", trig, 1);
  endtask

  initial begin
    int r, w;
    rst = 1'b1;
    enable = 1'b0;
    echo = 1'b0;
    win_lo = 9'd1;
    win_hi = 9'd5;
    repeat (3) step();
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_trig", trig, 0);
      chk("idle_busy", busy, 0);
    end
    restart();

    measure(20, 34, 1, 5, 1'b1, 0);   // nominal, 3 cm hit
    measure(20, 10, 1, 5, 1'b1, 0);   // 1 cm, on lower bound
    measure(20, 50, 1, 5, 1'b1, 0);   // 5 cm, on upper bound
    measure(20, 49, 1, 5, 1'b1, 0);   // 4 cm, hit
    measure(20, 0, 1, 5, 1'b1, 0);    // no echo
    measure(20, 300, 1, 5, 1'b1, 0);  // over-long echo
    measure(20, 180, 0, 20, 1'b1, 0); // saturates at 15
    measure(20, 199, 0, 20, 1'b1, 0); // longest valid echo
    measure(20, 200, 0, 20, 1'b1, 0); // shortest over-long echo
    measure(-2, 25, 0, 20, 1'b1, 0);  // rise lands on first WAIT_RISE cycle
    measure(-3, 40, 0, 20, 1'b1, 0);  // already high at WAIT_RISE entry
    measure(30, 5, 1, 5, 1'b1, 0);    // 0 cm
    measure(20, 34, 5, 1, 1'b1, 0);   // inverted window

    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) w = 0;
      else if (r < 8) w = $urandom_range(1, 199);
      else w = $urandom_range(200, 260);
      measure($urandom_range(0, 100), w, $urandom_range(0, 12), $urandom_range(0, 20), 1'b1, 0);
    end

    // Two hits 30 cycles apart extend the hold to 80 cycles.
    measure(20, 34, 1, 5, 1'b1, 1);
    enable = 1'b0;
    step();
    chk("stop_busy", busy, 0);
    restart();
    measure(0, 20, 0, 5, 1'b0, 0);

    measure(20, 100, 0, 20, 1'b1, 2);
    restart();
    measure(10, 60, 0, 20, 1'b0, 0);
    measure(10, 100, 0, 20, 1'b1, 3);
    restart();
    measure(15, 45, 0, 20, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
